sawtooth_seq_ctrl: RTL and testbench

- Front-end controller for the N1/N2 sawtooth counter datapath.
- Conditions the raw select button (synchronise, debounce, edge-detect) and sequences operand entry N1 then N2.
- Enforces N2 > N1 before the datapath may run; an invalid N2 is rejected through an error state.
- While running, issues a prescaled step enable to the counter, plus display data and state code for the 7-segment indicator.

---
 rtl/sawtooth_pkg.sv | 16 +
 rtl/btn_conditioner.sv | 58 +++++
 rtl/sawtooth_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sawtooth_seq_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sawtooth_pkg.sv
// Shared definitions for the sawtooth front-end controller.
// Holds the sequencer state encoding and the default operand width.
package sawtooth_pkg;

    localparam int DEF_DW = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GET_N1 = 3'd1,
        S_GET_N2 = 3'd2,
        S_CHECK  = 3'd3,
        S_RUN    = 3'd4,
        S_ERROR  = 3'd5
    } state_e;

endpackage

// File: rtl/btn_conditioner.sv
// Front-panel button conditioner: 2-flop synchroniser, debounce, rising-edge pulse.
// Ports: clk_i clock, rst_i async active-low reset, btn_i raw button,
//        press_o one-cycle pulse on each accepted (debounced) press.
module btn_conditioner #(
    parameter int DEB_CYCLES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Count consecutive samples that disagree with the accepted level;
    // any agreeing sample restarts the count.
    always_comb begin
        deb_d   = deb_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                deb_d   = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/sawtooth_seq_ctrl.sv
// Sequencer for the N1/N2 sawtooth datapath: operand entry, N2>N1 check, stepping.
// Ports: clc_i clock, rst_i async active-low reset, btn_i raw select button,
//        hold_i pause, din_i operand switches; n1_ld_o/n2_ld_o + ld_data_o load
//        strobes and data, run_o, step_en_o, err_o, dind_o indicator data, state_o.
module sawtooth_seq_ctrl
    import sawtooth_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int DEB_CYCLES = 2,
    parameter int STEP_DIV   = 1,
    parameter int ERR_HOLD   = 8
) (
    input  logic          clc_i,
    input  logic          rst_i,
    input  logic          btn_i,
    input  logic          hold_i,
    input  logic [DW-1:0] din_i,
    output logic          n1_ld_o,
    output logic          n2_ld_o,
    output logic [DW-1:0] ld_data_o,
    output logic          run_o,
    output logic          step_en_o,
    output logic          err_o,
    output logic [DW-1:0] dind_o,
    output logic [2:0]    state_o
);

    localparam int PW = $clog2(STEP_DIV + 1);
    localparam int HW = $clog2(ERR_HOLD + 1);

    logic          press;
    state_e        state_q, state_d;
    logic [DW-1:0] n1_q, n1_d;
    logic [DW-1:0] n2_q, n2_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          n1_ld_q, n1_ld_d;
    logic          n2_ld_q, n2_ld_d;
    logic [DW-1:0] ld_data_q, ld_data_d;
    logic          run_q, run_d;
    logic          step_q, step_d;
    logic          err_q, err_d;
    logic [DW-1:0] dind_q, dind_d;
    logic          pre_tc;
    logic          hold_tc;
    logic          n2_gt;

    btn_conditioner #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn (
        .clk_i  (clc_i),
        .rst_i  (rst_i),
        .btn_i  (btn_i),
        .press_o(press)
    );

    assign pre_tc  = (pre_q == PW'(STEP_DIV - 1));
    assign hold_tc = (hcnt_q == HW'(ERR_HOLD - 1));
    assign n2_gt   = (n2_q > n1_q);

    always_ff @(posedge clc_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            n1_q      <= '0;
            n2_q      <= '0;
            pre_q     <= '0;
            hcnt_q    <= '0;
            n1_ld_q   <= 1'b0;
            n2_ld_q   <= 1'b0;
            ld_data_q <= '0;
            run_q     <= 1'b0;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            dind_q    <= '0;
        end else begin
            state_q   <= state_d;
            n1_q      <= n1_d;
            n2_q      <= n2_d;
            pre_q     <= pre_d;
            hcnt_q    <= hcnt_d;
            n1_ld_q   <= n1_ld_d;
            n2_ld_q   <= n2_ld_d;
            ld_data_q <= ld_data_d;
            run_q     <= run_d;
            step_q    <= step_d;
            err_q     <= err_d;
            dind_q    <= dind_d;
        end
    end

    // Prescaler and error timer only count in their own state and read
    // zero everywhere else, so every entry starts from a clean count.
    always_comb begin
        state_d = state_q;
        n1_d    = n1_q;
        n2_d    = n2_q;
        pre_d   = '0;
        hcnt_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (press) state_d = S_GET_N1;
            end
            S_GET_N1: begin
                if (press) begin
                    n1_d    = din_i;
                    state_d = S_GET_N2;
                end
            end
            S_GET_N2: begin
                if (press) begin
                    n2_d    = din_i;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = n2_gt ? S_RUN : S_ERROR;
            end
            S_RUN: begin
                if (press) begin
                    state_d = S_GET_N1;
                end else if (hold_i) begin
                    pre_d = pre_q;
                end else if (!pre_tc) begin
                    pre_d = pre_q + 1'b1;
                end
            end
            S_ERROR: begin
                if (press || hold_tc) begin
                    state_d = S_GET_N2;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are computed for the cycle after the coming edge and registered.
    always_comb begin
        n1_ld_d   = (state_q == S_GET_N1) && press;
        n2_ld_d   = (state_q == S_CHECK) && n2_gt;
        ld_data_d = ld_data_q;
        if (n1_ld_d) begin
            ld_data_d = din_i;
        end else if (n2_ld_d) begin
            ld_data_d = n2_q;
        end
        run_d  = (state_d == S_RUN);
        err_d  = (state_d == S_ERROR);
        step_d = (state_q == S_RUN) && !press && !hold_i && pre_tc;
        unique case (1'b1)
            (state_d == S_IDLE):   dind_d = '0;
            (state_d == S_GET_N1),
            (state_d == S_GET_N2): dind_d = din_i;
            default:               dind_d = n2_d;
        endcase
    end

    assign n1_ld_o   = n1_ld_q;
    assign n2_ld_o   = n2_ld_q;
    assign ld_data_o = ld_data_q;
    assign run_o     = run_q;
    assign step_en_o = step_q;
    assign err_o     = err_q;
    assign dind_o    = dind_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_sawtooth_seq_ctrl.sv
// Testbench for sawtooth_seq_ctrl: two instances (STEP_DIV 3 and 1) share stimulus
// and are checked every cycle against a cycle model plus directed literal checks.
module tb_sawtooth_seq_ctrl;

    localparam int DW  = 8;
    localparam int DEB = 2;
    localparam int EH  = 8;

    logic          clk;
    logic          rst_n;
    logic          btn;
    logic          hold;
    logic [DW-1:0] din;

    logic          n1ld[2];
    logic          n2ld[2];
    logic [DW-1:0] ldd[2];
    logic          run[2];
    logic          step[2];
    logic          err[2];
    logic [DW-1:0] dind[2];
    logic [2:0]    st[2];

    int checks = 0;
    int errors = 0;

    sawtooth_seq_ctrl #(
        .DW(DW), .DEB_CYCLES(DEB), .STEP_DIV(3), .ERR_HOLD(EH)
    ) u_dut0 (
        .clc_i(clk), .rst_i(rst_n), .btn_i(btn), .hold_i(hold), .din_i(din),
        .n1_ld_o(n1ld[0]), .n2_ld_o(n2ld[0]), .ld_data_o(ldd[0]),
        .run_o(run[0]), .step_en_o(step[0]), .err_o(err[0]),
        .dind_o(dind[0]), .state_o(st[0])
    );

    sawtooth_seq_ctrl #(
        .DW(DW), .DEB_CYCLES(DEB), .STEP_DIV(1), .ERR_HOLD(EH)
    ) u_dut1 (
        .clc_i(clk), .rst_i(rst_n), .btn_i(btn), .hold_i(hold), .din_i(din),
        .n1_ld_o(n1ld[1]), .n2_ld_o(n2ld[1]), .ld_data_o(ldd[1]),
        .run_o(run[1]), .step_en_o(step[1]), .err_o(err[1]),
        .dind_o(dind[1]), .state_o(st[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int st; int n1; int n2; int pre; int eh;
        int s1; int s2; int deb; int cnt; int press;
        int n1ld; int n2ld; int ld; int run; int step; int err; int dind;
    } mdl_t;

    mdl_t m[2];

    function automatic mdl_t mstep(mdl_t c, int sd, int b, int h, int d);
        mdl_t r = c;
        r.n1ld = 0;
        r.n2ld = 0;
        r.step = 0;
        case (c.st)
            0: if (c.press != 0) r.st = 1;
            1: if (c.press != 0) begin
                r.n1 = d; r.n1ld = 1; r.ld = d; r.st = 2;
            end
            2: if (c.press != 0) begin
                r.n2 = d; r.st = 3;
            end
            3: if (c.n2 > c.n1) begin
                r.n2ld = 1; r.ld = c.n2; r.st = 4;
            end else begin
                r.st = 5;
            end
            4: if (c.press != 0) begin
                r.st = 1;
            end else if (h == 0) begin
                r.pre = (c.pre + 1) % sd;
                r.step = (c.pre == sd - 1) ? 1 : 0;
            end
            5: if (c.press != 0 || c.eh + 1 == EH) r.st = 2;
               else r.eh = c.eh + 1;
            default: r.st = 0;
        endcase
        if (r.st != 4) r.pre = 0;
        if (r.st != 5) r.eh = 0;
        r.run = (r.st == 4) ? 1 : 0;
        r.err = (r.st == 5) ? 1 : 0;
        if (r.st == 0) r.dind = 0;
        else if (r.st == 1 || r.st == 2) r.dind = d;
        else r.dind = r.n2;
        // button: level accepted after DEB consecutive disagreeing synced samples
        r.s1 = b;
        r.s2 = c.s1;
        r.press = 0;
        if (c.s2 != c.deb) begin
            r.cnt = c.cnt + 1;
            if (r.cnt == DEB) begin
                r.deb = c.s2;
                r.cnt = 0;
                r.press = c.s2;
            end
        end else begin
            r.cnt = 0;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m[0] <= '{default: 0};
            m[1] <= '{default: 0};
        end else begin
            m[0] <= mstep(m[0], 3, int'(btn), int'(hold), int'(din));
            m[1] <= mstep(m[1], 1, int'(btn), int'(hold), int'(din));
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d n1_ld_o", i), int'(n1ld[i]), m[i].n1ld);
            chk($sformatf("u%0d n2_ld_o", i), int'(n2ld[i]), m[i].n2ld);
            chk($sformatf("u%0d ld_data_o", i), int'(ldd[i]), m[i].ld);
            chk($sformatf("u%0d run_o", i), int'(run[i]), m[i].run);
            chk($sformatf("u%0d step_en_o", i), int'(step[i]), m[i].step);
            chk($sformatf("u%0d err_o", i), int'(err[i]), m[i].err);
            chk($sformatf("u%0d dind_o", i), int'(dind[i]), m[i].dind);
            chk($sformatf("u%0d state_o", i), int'(st[i]), m[i].st);
        end
    end

    // Two-cycle button pulse; returns on the negedge after the FSM has acted.
    task automatic tap();
        btn = 1'b1;
        repeat (2) @(negedge clk);
        btn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst run_o", int'(run[0]), 0);
        chk("rst state_o", int'(st[0]), 0);
        chk("rst dind_o", int'(dind[0]), 0);
        chk("rst ld_data_o", int'(ldd[0]), 0);
        chk("rst step_en_o u1", int'(step[1]), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post-rst n1_ld_o", int'(n1ld[0]), 0);
            chk("post-rst n2_ld_o", int'(n2ld[0]), 0);
        end
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        btn   = 1'b0;
        hold  = 1'b0;
        din   = '0;
        repeat (2) @(negedge clk);
        chk("reset state_o", int'(st[0]), 0);
        chk("reset run_o", int'(run[0]), 0);
        chk("reset dind_o", int'(dind[0]), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // bounce 1,0,1,0 then steady high
        btn = 1'b1; @(negedge clk);
        btn = 1'b0; @(negedge clk);
        btn = 1'b1; @(negedge clk);
        btn = 1'b0; @(negedge clk);
        btn = 1'b1;
        repeat (4) @(negedge clk);
        chk("bounce early state_o", int'(st[0]), 0);
        @(negedge clk);
        chk("bounce state_o", int'(st[0]), 1);
        btn = 1'b0;
        repeat (6) @(negedge clk);

        // single-cycle glitch is ignored
        btn = 1'b1; @(negedge clk);
        btn = 1'b0;
        repeat (8) @(negedge clk);
        chk("glitch state_o", int'(st[0]), 1);

        din = 8'd10;
        tap();
        chk("n1 n1_ld_o", int'(n1ld[0]), 1);
        chk("n1 ld_data_o", int'(ldd[0]), 10);
        chk("n1 state_o", int'(st[0]), 2);
        @(negedge clk);
        chk("n1 strobe width", int'(n1ld[0]), 0);
        chk("n1 ld_data hold", int'(ldd[0]), 10);

        din = 8'd20;
        tap();
        chk("n2 check state_o", int'(st[0]), 3);
        chk("n2 no early strobe", int'(n2ld[0]), 0);
        @(negedge clk);
        chk("n2 n2_ld_o", int'(n2ld[0]), 1);
        chk("n2 ld_data_o", int'(ldd[0]), 20);
        chk("n2 run_o", int'(run[0]), 1);
        chk("n2 state_o", int'(st[0]), 4);
        chk("n2 dind_o", int'(dind[0]), 20);

        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (step[0]) cnt++;
        end
        chk("div3 step count", cnt, 3);

        hold = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold step u0", int'(step[0]), 0);
            chk("hold step u1", int'(step[1]), 0);
        end
        hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("resume step u0", int'(step[0]), (i == 2) ? 1 : 0);
        end

        cnt = 0;
        while (m[0].pre != 1 && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("align timeout", (cnt < 10) ? 1 : 0, 1);
        tap();
        chk("tc press step", int'(step[0]), 0);
        chk("tc press run_o", int'(run[0]), 0);
        chk("tc press state_o", int'(st[0]), 1);

        din = 8'd20;
        tap();
        tap();
        chk("eq check state_o", int'(st[0]), 3);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (err[0]) cnt++;
        end
        chk("eq err cycles", cnt, EH);
        chk("eq back state_o", int'(st[0]), 2);

        din = 8'd5;
        tap();
        chk("lt check state_o", int'(st[0]), 3);
        tap();
        chk("err press state_o", int'(st[0]), 2);
        chk("err press err_o", int'(err[0]), 0);

        din = 8'd30;
        tap();
        @(negedge clk);
        chk("retry n2_ld_o", int'(n2ld[0]), 1);
        chk("retry ld_data_o", int'(ldd[0]), 30);
        chk("retry run_o", int'(run[0]), 1);
        repeat (3) @(negedge clk);
        mid_reset();

        tap();
        din = 8'd7;
        tap();
        repeat (2) @(negedge clk);
        chk("get_n2 dind_o", int'(dind[0]), 7);
        mid_reset();

        tap();
        din = 8'd255;
        tap();
        tap();
        chk("max check state_o", int'(st[0]), 3);
        @(negedge clk);
        chk("max err_o", int'(err[0]), 1);
        chk("max state_o", int'(st[0]), 5);
        chk("max n2_ld_o", int'(n2ld[0]), 0);

        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
